pwm_cfg_arb: RTL and testbench

- Round-robin configuration arbiter for a bank of `pwm` channels.
- Lets NREQ requesters each write a duty value (uptime) into any of NCH channels.
- All channels share one `uptime` bus and each channel has its own `cs` strobe.
- Strobes are timed so the channel's uptime latch is never open on the clock edge where the channel reloads its period. The block sits between software/control masters and the PWM bank, on the PWM clock and reset.

---
 rtl/pwm_cfg_arb.sv | 137 +++++++++++++
 tb/tb_pwm_cfg_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_arb.sv
// Round-robin arbiter writing requester duty values into a PWM bank over a shared
// uptime bus, timing each channel strobe away from the PWM period reload edge.
module pwm_cfg_arb #(
  parameter int NREQ = 4,
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int DW   = 3
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*CHW-1:0] req_ch,
  input  logic [NREQ*DW-1:0]  req_duty,
  output logic [NREQ-1:0]     ack,
  output logic                err,
  output logic [DW-1:0]       pwm_uptime,
  output logic [NCH-1:0]      pwm_cs,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   phase_q, phase_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [DW-1:0]   uptime_q, uptime_d;
  logic [NCH-1:0]  cs_q, cs_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   sel;
  logic [PW-1:0]   cand;
  logic            found;
  logic            phase_last;
  logic            ch_valid;

  assign phase_last = (phase_q == '1);
  assign ch_valid   = (32'(ch_q) < NCH);

  // First requesting index at or after ptr, scanning cyclically.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      ch_q     <= '0;
      uptime_q <= '0;
      cs_q     <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      ch_q     <= ch_d;
      uptime_q <= uptime_d;
      cs_q     <= cs_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    ch_d    = ch_q;
    phase_d = phase_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SETUP;
          win_d   = sel;
          ch_d    = req_ch[sel*CHW +: CHW];
        end
      end
      // Holding SETUP through the last phase keeps the strobe off the reload edge.
      SETUP:   if (!phase_last) state_d = STROBE;
      STROBE:  state_d = DONE;
      DONE: begin
        state_d = IDLE;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uptime_d = uptime_q;
    cs_d     = '0;
    ack_d    = '0;
    err_d    = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: if (found) uptime_d = req_duty[sel*DW +: DW];
      SETUP: begin
        if (!phase_last) begin
          for (int unsigned c = 0; c < NCH; c++) cs_d[c] = (32'(ch_q) == c);
        end
      end
      STROBE: begin
        for (int unsigned r = 0; r < NREQ; r++) ack_d[r] = (32'(win_q) == r);
        err_d = !ch_valid;
      end
      default: ;
    endcase
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign pwm_uptime = uptime_q;
  assign pwm_cs     = cs_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pwm_cfg_arb.sv
// Scoreboard bench for pwm_cfg_arb: directed stimulus pushes expected acks/strobes,
// per-DUT monitors pop and compare whenever an output pulse appears.
module tb_pwm_cfg_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [7:0]  ch_a, ch_b;
  logic [11:0] duty_a, duty_b;
  logic [3:0]  ack_a, ack_b;
  logic        err_a, err_b;
  logic [2:0]  up_a, up_b;
  logic [3:0]  cs_a;
  logic [2:0]  cs_b;
  logic        busy_a, busy_b;
  logic [2:0]  tb_phase;

  always #5 clk = ~clk;

  pwm_cfg_arb #(.NREQ(4), .NCH(4), .CHW(2), .DW(3)) u_dut_a (
    .clkin(clk), .reset(rst), .req(req_a), .req_ch(ch_a), .req_duty(duty_a),
    .ack(ack_a), .err(err_a), .pwm_uptime(up_a), .pwm_cs(cs_a), .busy(busy_a)
  );

  pwm_cfg_arb #(.NREQ(4), .NCH(3), .CHW(2), .DW(3)) u_dut_b (
    .clkin(clk), .reset(rst), .req(req_b), .req_ch(ch_b), .req_duty(duty_b),
    .ack(ack_b), .err(err_b), .pwm_uptime(up_b), .pwm_cs(cs_b), .busy(busy_b)
  );

  // Reference phase counter: same reset, same clock as the DUT/PWM counter.
  always @(posedge clk) tb_phase <= rst ? 3'd0 : tb_phase + 3'd1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  typedef struct { logic [3:0] ack; logic err; logic [2:0] duty; } ack_t;
  typedef struct { logic [3:0] cs; logic [2:0] duty; } cs_t;

  ack_t qa_ack[$];
  ack_t qb_ack[$];
  cs_t  qa_cs[$];
  ack_t ea, eb;
  cs_t  ec;

  always @(negedge clk) begin
    if (ack_a != 4'd0 || err_a) begin
      if (qa_ack.size() == 0) chk("A unexpected ack", {27'd0, ack_a, err_a}, 32'd0);
      else begin
        ea = qa_ack.pop_front();
        chk("A ack", ack_a, ea.ack);
        chk("A err", err_a, ea.err);
        chk("A uptime@ack", up_a, ea.duty);
      end
    end
    if (cs_a != 4'd0) begin
      if (qa_cs.size() == 0) chk("A unexpected cs", cs_a, 32'd0);
      else begin
        ec = qa_cs.pop_front();
        chk("A cs", cs_a, ec.cs);
        chk("A uptime@cs", up_a, ec.duty);
      end
    end
  end

  always @(negedge clk) begin
    if (ack_b != 4'd0 || err_b) begin
      if (qb_ack.size() == 0) chk("B unexpected ack", {27'd0, ack_b, err_b}, 32'd0);
      else begin
        eb = qb_ack.pop_front();
        chk("B ack", ack_b, eb.ack);
        chk("B err", err_b, eb.err);
        chk("B uptime@ack", up_b, eb.duty);
      end
    end
    if (cs_b != 3'd0) chk("B unexpected cs", cs_b, 32'd0);
  end

  task automatic set_req(input bit b, input int r, input int ch, input int duty);
    logic [1:0] c2;
    logic [2:0] d3;
    c2 = ch[1:0];
    d3 = duty[2:0];
    if (!b) begin
      ch_a[r*2 +: 2] = c2; duty_a[r*3 +: 3] = d3; req_a[r] = 1'b1;
    end else begin
      ch_b[r*2 +: 2] = c2; duty_b[r*3 +: 3] = d3; req_b[r] = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit b, output logic [3:0] a);
    a = 4'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = b ? ack_b : ack_a;
      if (a != 4'd0) break;
    end
    if (a == 4'd0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack timeout: got none within 20 cycles");
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (tb_phase == p) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL phase wait: got %0d want %0d", tb_phase, p);
  endtask

  // One write, checked cycle by cycle from the grant edge.
  task automatic run_one(input bit b, input int r, input int ch, input int duty,
                         input int stall, input bit valid);
    logic [3:0] s_cs, s_ack;
    logic [2:0] s_up, d3;
    logic       s_err, s_busy;
    d3 = duty[2:0];
    set_req(b, r, ch, duty);
    if (!b) begin
      qa_ack.push_back('{ack: 4'(1 << r), err: !valid, duty: d3});
      if (valid) qa_cs.push_back('{cs: 4'(1 << ch), duty: d3});
    end else begin
      qb_ack.push_back('{ack: 4'(1 << r), err: !valid, duty: d3});
    end
    for (int k = 1; k <= 4 + stall; k++) begin
      @(negedge clk);
      s_cs   = b ? {1'b0, cs_b} : cs_a;
      s_ack  = b ? ack_b : ack_a;
      s_err  = b ? err_b : err_a;
      s_up   = b ? up_b : up_a;
      s_busy = b ? busy_b : busy_a;
      if (k == 1) begin
        chk("uptime in setup", s_up, d3);
        chk("busy in setup", s_busy, 1);
        if (!b) duty_a[r*3 +: 3] = ~d3; else duty_b[r*3 +: 3] = ~d3;
      end
      chk($sformatf("cs cycle %0d", k), s_cs, (k == 2 + stall && valid) ? 32'(1 << ch) : 32'd0);
      chk($sformatf("ack cycle %0d", k), s_ack, (k == 3 + stall) ? 32'(1 << r) : 32'd0);
      chk($sformatf("err cycle %0d", k), s_err, (k == 3 + stall && !valid) ? 32'd1 : 32'd0);
      if (k == 3 + stall) begin
        if (!b) req_a[r] = 1'b0; else req_b[r] = 1'b0;
      end
      if (k == 4 + stall) begin
        chk("busy after done", s_busy, 0);
        chk("uptime hold", s_up, d3);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    rst = 1'b1;
    req_a = 4'b1111; req_b = 4'd0;
    ch_a = 8'b11_10_01_00; duty_a = 12'b100_011_010_001;
    ch_b = 8'd0; duty_b = 12'd0;

    // Reset held with all requests pending: everything stays quiet.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst ack", ack_a, 0);
      chk("rst err", err_a, 0);
      chk("rst cs", cs_a, 0);
      chk("rst uptime", up_a, 0);
      chk("rst busy", busy_a, 0);
      chk("rst busy B", busy_b, 0);
    end
    rst = 1'b0;

    // Round robin over all four, each dropping after its ack.
    for (int i = 0; i < 4; i++) begin
      qa_ack.push_back('{ack: 4'(1 << i), err: 1'b0, duty: 3'(i + 1)});
      qa_cs.push_back('{cs: 4'(1 << i), duty: 3'(i + 1)});
    end
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, a);
      chk($sformatf("rr grant %0d", i), a, 32'(1 << i));
      req_a = req_a & ~a;
    end
    req_a = 4'b1001;
    qa_ack.push_back('{ack: 4'b0001, err: 1'b0, duty: 3'd1});
    qa_cs.push_back('{cs: 4'b0001, duty: 3'd1});
    qa_ack.push_back('{ack: 4'b1000, err: 1'b0, duty: 3'd4});
    qa_cs.push_back('{cs: 4'b1000, duty: 3'd4});
    wait_ack(1'b0, a);
    chk("rr 1001 first", a, 32'b0001);
    req_a = req_a & ~a;
    wait_ack(1'b0, a);
    chk("rr 1001 second", a, 32'b1000);
    req_a = req_a & ~a;

    // Single write away from wrap, then one that lands SETUP on phase 7.
    wait_phase(3'd2);
    run_one(1'b0, 2, 1, 5, 0, 1'b1);
    wait_phase(3'd6);
    run_one(1'b0, 2, 1, 5, 1, 1'b1);

    // Invalid channel on the 3-channel instance.
    wait_phase(3'd2);
    run_one(1'b1, 1, 3, 6, 0, 1'b0);

    // Reset during STROBE: strobe dropped, no ack, pointer back to 0.
    wait_phase(3'd2);
    set_req(1'b0, 3, 2, 3);
    qa_cs.push_back('{cs: 4'b0100, duty: 3'd3});
    @(negedge clk);
    @(negedge clk);
    chk("strobe before reset", cs_a, 32'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("reset cs", cs_a, 0);
    chk("reset ack", ack_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset uptime", up_a, 0);
    req_a = 4'd0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    set_req(1'b0, 0, 0, 1);
    set_req(1'b0, 3, 3, 4);
    qa_ack.push_back('{ack: 4'b0001, err: 1'b0, duty: 3'd1});
    qa_cs.push_back('{cs: 4'b0001, duty: 3'd1});
    qa_ack.push_back('{ack: 4'b1000, err: 1'b0, duty: 3'd4});
    qa_cs.push_back('{cs: 4'b1000, duty: 3'd4});
    wait_ack(1'b0, a);
    chk("ptr after reset", a, 32'b0001);
    req_a = req_a & ~a;
    wait_ack(1'b0, a);
    chk("grant after ptr 0", a, 32'b1000);
    req_a = req_a & ~a;

    repeat (8) @(negedge clk);
    chk("A ack queue drained", qa_ack.size(), 0);
    chk("A cs queue drained", qa_cs.size(), 0);
    chk("B ack queue drained", qb_ack.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
